intersection_controller: RTL and testbench
==========================================

# intersection_controller

Parametrised multi-approach traffic signal controller. It is the successor to the single-head light sequencer. It drives `NUM_DIR` signal heads in round-robin order through green, yellow and an all-red clearance interval, with phase durations set by parameters. An optional demand-skip mode omits approaches with no vehicle request. It sits under the intersection top level and feeds the lamp-driver block directly.

## Interface
- `NUM_DIR`, 2: number of approaches. Legal range 2..16.
- `GREEN`, 7: green duration in cycles. Must be at least 1.
- `YELLOW`, 3: yellow duration in cycles. Must be at least 1.
- `ALL_RED`, 2: all-red clearance duration in cycles. Must be at least 1.
- `TIMER_W`, 8: phase timer width. All durations must be less than 2^TIMER_W.
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `veh_req`  in  NUM_DIR  per-approach vehicle demand, level-sensitive. Used only with `DEMAND_SKIP_EN`.
- `red`  out  NUM_DIR  red lamp per approach
- `yellow`  out  NUM_DIR  yellow lamp per approach
- `green`  out  NUM_DIR  green lamp per approach
- `phase`  out  2  current phase: ALL_RED=0, GREEN=1, YELLOW=2
- `active_dir`  out  max(1,$clog2(NUM_DIR))  approach owning the current or most recent green
- `phase_start`  out  1  one-cycle pulse in the first cycle of every phase

## Operation
- There are three states.
  - ALL_RED: every approach is red.
  - GREEN: `green[active_dir]` is high; all other approaches are red.
  - YELLOW: `yellow[active_dir]` is high; all other approaches are red.
- Transitions run in a fixed cycle: ALL_RED -> GREEN -> YELLOW -> ALL_RED.
- On ALL_RED -> GREEN, `active_dir` advances to (active_dir+1) mod NUM_DIR.
- Invariant: each approach has exactly one lamp set at all times, and at most one approach is non-red.
- Phase timer:
  - Loaded with the duration of the phase being entered.
  - Decrements while greater than 1.
  - When it equals 1, the transition occurs on that clock edge.
  - Result: every phase lasts exactly its parameter value in cycles.
- Arithmetic:
  - The timer is unsigned `TIMER_W` bits and never underflows.
  - Direction advance wraps from NUM_DIR-1 to 0.
- Reset values:
  - State ALL_RED, `red` all ones, `yellow` and `green` zero.
  - `phase`=0, `active_dir`=NUM_DIR-1, timer=ALL_RED.
  - `phase_start`=1, because reset counts as the start of the ALL_RED phase.
- Reset asserted mid-phase aborts immediately to the reset values. No yellow is inserted.
- All outputs are registered; there are no combinational paths from input to output.

## Timing
- After reset release, the first green appears on approach 0 after ALL_RED edges.
- One full rotation, with no skipping, takes NUM_DIR*(GREEN+YELLOW+ALL_RED) cycles.
- `phase_start` is high in the same cycle the new lamp pattern first appears.
- `veh_req` is sampled only in the cycle where ALL_RED has timer==1, and only when `DEMAND_SKIP_EN` is defined.

## Configuration
- Macro: `INTERSECTION_DEMAND_SKIP_EN`.
- Defined:
  - At the end of ALL_RED, the next green goes to the first approach with `veh_req` set, searching from active_dir+1 in round-robin order. This wraps and may return to `active_dir` itself.
  - If no request is set, the controller stays in ALL_RED with the timer held at 1 and re-evaluates every cycle. `phase_start` does not pulse during this wait.
  - A request is not cleared by the controller; it is the requester's responsibility.
- Undefined:
  - `veh_req` is ignored and left unconnected internally.
  - Behaviour is pure round-robin, identical to the Operation section.

## Structure
- Package `intersection_pkg` holds:
  - `phase_e`, a 2-bit enum: PH_ALL_RED, PH_GREEN, PH_YELLOW.
  - Lamp-state localparams shared with the lamp-driver.
- Sub-module `rr_next_dir` is combinational. It takes the current direction and a request mask and returns the next direction plus a `found` flag.
  - With the macro undefined, it is fed an all-ones mask.
- The phase timer and FSM live in the top module.

## Test plan
- Reset, NUM_DIR=3, GREEN=4, YELLOW=2, ALL_RED=1, no skip: all red during reset. After release, `green[0]` is high on cycles 1-4, `yellow[0]` on cycles 5-6, all red on cycle 7, and `green[1]` from cycle 8.
- Wrap-around with the same configuration: after 21 cycles `active_dir` returns to 0. `phase_start` pulses exactly 9 times per rotation.
- Reset asserted during YELLOW of approach 1: in the next cycle all lamps are red, `active_dir`=2 and `phase`=0, with no further yellow.
- Skip mode, `veh_req`=3'b100 held: green is granted only to approach 2, and each repeat is separated by YELLOW+ALL_RED.
- Skip mode, `veh_req`=0 for 10 cycles, then 3'b010: the controller stays all red with `phase_start` low. Green[1] appears on the edge after the request is sampled.
- Invariant assertion, run continuously over random `veh_req`: onehot(red|yellow|green per approach) holds, and at most one approach is non-red.

Source files
------------

// File: rtl/intersection_pkg.sv
// Shared types and constants for the intersection signal controller.
// The lamp encodings are also used by the lamp-driver block.
package intersection_pkg;

  // Controller phase, as seen on the phase output.
  typedef enum logic [1:0] {
    PH_ALL_RED = 2'd0,
    PH_GREEN   = 2'd1,
    PH_YELLOW  = 2'd2
  } phase_e;

  // Per-approach lamp state, packed as {red, yellow, green}; always one-hot.
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  // Width of a direction index; never below one bit.
  function automatic int dir_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/intersection_controller_rr_next_dir.sv
// Combinational round-robin picker: starting at cur+1 and wrapping, returns
// the first direction whose mask bit is set. The search covers cur itself
// last, so a lone requester can be granted again. found is low when the mask
// is empty, in which case nxt_dir simply echoes cur.
module rr_next_dir #(
  parameter int NUM_DIR = 2,
  parameter int DIR_W   = 1
) (
  input  logic [DIR_W-1:0]   cur,
  input  logic [NUM_DIR-1:0] mask,
  output logic [DIR_W-1:0]   nxt_dir,
  output logic               found
);

  // Scan offsets 1..NUM_DIR; the first hit wins.
  always_comb begin
    int idx;
    idx     = 0;
    nxt_dir = cur;
    found   = 1'b0;
    for (int k = 1; k <= NUM_DIR; k++) begin
      idx = (int'(cur) + k) % NUM_DIR;
      if (!found && mask[idx]) begin
        found   = 1'b1;
        nxt_dir = DIR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/intersection_controller.sv
// Multi-approach traffic signal controller. Approaches are served in
// round-robin order through GREEN -> YELLOW -> ALL_RED; each phase lasts
// exactly its parameter value in cycles. All outputs are registered, and the
// phase output doubles as the visible FSM state.
// Optional feature macro: INTERSECTION_DEMAND_SKIP_EN. When defined, the next
// green goes to the next approach with veh_req set, and the controller waits
// in ALL_RED (timer held at 1) while no request is present. When undefined,
// veh_req is ignored and rotation is unconditional.
module intersection_controller
  import intersection_pkg::*;
#(
  parameter int  NUM_DIR = 2,
  parameter int  GREEN   = 7,
  parameter int  YELLOW  = 3,
  parameter int  ALL_RED = 2,
  parameter int  TIMER_W = 8,
  localparam int DIR_W   = dir_width(NUM_DIR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_DIR-1:0] veh_req,
  output logic [NUM_DIR-1:0] red,
  output logic [NUM_DIR-1:0] yellow,
  output logic [NUM_DIR-1:0] green,
  output logic [1:0]         phase,
  output logic [DIR_W-1:0]   active_dir,
  output logic               phase_start
);

  localparam logic [TIMER_W-1:0] T_GREEN   = TIMER_W'(GREEN);
  localparam logic [TIMER_W-1:0] T_YELLOW  = TIMER_W'(YELLOW);
  localparam logic [TIMER_W-1:0] T_ALL_RED = TIMER_W'(ALL_RED);
  localparam logic [TIMER_W-1:0] T_ONE     = TIMER_W'(1);
  localparam logic [DIR_W-1:0]   DIR_LAST  = DIR_W'(NUM_DIR - 1);

  phase_e               phase_q;
  logic [TIMER_W-1:0]   timer_q;
  logic [NUM_DIR-1:0]   req_mask;
  logic [DIR_W-1:0]     cand_dir;
  logic                 cand_found;

`ifdef INTERSECTION_DEMAND_SKIP_EN
  assign req_mask = veh_req;
`else
  // Pure rotation: every approach always counts as requesting.
  logic unused_veh_req;
  assign unused_veh_req = ^veh_req;
  assign req_mask       = '1;
`endif

  rr_next_dir #(
    .NUM_DIR (NUM_DIR),
    .DIR_W   (DIR_W)
  ) u_rr (
    .cur     (active_dir),
    .mask    (req_mask),
    .nxt_dir (cand_dir),
    .found   (cand_found)
  );

  // Build the {red, yellow, green} vectors with one lamp on approach dir and
  // red everywhere else.
  function automatic logic [3*NUM_DIR-1:0] lamps_for(input logic [DIR_W-1:0] dir,
                                                      input logic [2:0] lamp);
    logic [NUM_DIR-1:0] r, y, g;
    r = '1;
    y = '0;
    g = '0;
    for (int i = 0; i < NUM_DIR; i++) begin
      if (DIR_W'(i) == dir) begin
        r[i] = lamp[2];
        y[i] = lamp[1];
        g[i] = lamp[0];
      end
    end
    return {r, y, g};
  endfunction

  // Phase FSM, phase timer and registered lamp outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q                <= PH_ALL_RED;
      timer_q                <= T_ALL_RED;
      active_dir             <= DIR_LAST;
      {red, yellow, green}   <= lamps_for(DIR_LAST, LAMP_R);
      phase_start            <= 1'b1;
    end else begin
      phase_start <= 1'b0;
      if (timer_q != T_ONE) begin
        timer_q <= timer_q - T_ONE;
      end else begin
        case (phase_q)
          PH_ALL_RED: begin
            // With no candidate the timer stays at 1 and we re-check next cycle.
            if (cand_found) begin
              phase_q              <= PH_GREEN;
              timer_q              <= T_GREEN;
              active_dir           <= cand_dir;
              {red, yellow, green} <= lamps_for(cand_dir, LAMP_G);
              phase_start          <= 1'b1;
            end
          end
          PH_GREEN: begin
            phase_q              <= PH_YELLOW;
            timer_q              <= T_YELLOW;
            {red, yellow, green} <= lamps_for(active_dir, LAMP_Y);
            phase_start          <= 1'b1;
          end
          default: begin
            phase_q              <= PH_ALL_RED;
            timer_q              <= T_ALL_RED;
            {red, yellow, green} <= lamps_for(active_dir, LAMP_R);
            phase_start          <= 1'b1;
          end
        endcase
      end
    end
  end

  assign phase = phase_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Bench for intersection_controller (NUM_DIR=3, GREEN=4, YELLOW=2, ALL_RED=1).
// Expected outputs come from a closed-form schedule: after reset the first
// ALL_RED cycles, then back-to-back rotations of GREEN+YELLOW+ALL_RED.
module tb_intersection_controller;

  localparam int N  = 3;
  localparam int G  = 4;
  localparam int Y  = 2;
  localparam int A  = 1;
  localparam int P  = G + Y + A;

  logic         clk;
  logic         rst;
  logic [N-1:0] veh_req;
  logic [N-1:0] red, yellow, green;
  logic [1:0]   phase;
  logic [1:0]   active_dir;
  logic         phase_start;

  int n_tests = 0;
  int n_fail  = 0;
  int start_cnt;

  intersection_controller #(
    .NUM_DIR (N),
    .GREEN   (G),
    .YELLOW  (Y),
    .ALL_RED (A),
    .TIMER_W (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .veh_req     (veh_req),
    .red         (red),
    .yellow      (yellow),
    .green       (green),
    .phase       (phase),
    .active_dir  (active_dir),
    .phase_start (phase_start)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs t cycles after reset release. fixed_dir < 0 means pure
  // rotation; otherwise every grant goes to fixed_dir.
  task automatic model(input int t, input int fixed_dir,
                       output logic [N-1:0] er, output logic [N-1:0] ey,
                       output logic [N-1:0] eg, output logic [1:0] eph,
                       output logic [1:0] edir, output logic est);
    int u, k, r;
    er = '1; ey = '0; eg = '0;
    if (t < A) begin
      eph  = 2'd0;
      edir = 2'(N - 1);
      est  = (t == 0);
    end else begin
      u    = t - A;
      k    = u / P;
      r    = u % P;
      edir = (fixed_dir >= 0) ? 2'(fixed_dir) : 2'(k % N);
      est  = (r == 0) || (r == G) || (r == G + Y);
      if (r < G) begin
        eph = 2'd1; eg[edir] = 1'b1; er[edir] = 1'b0;
      end else if (r < G + Y) begin
        eph = 2'd2; ey[edir] = 1'b1; er[edir] = 1'b0;
      end else begin
        eph = 2'd0;
      end
    end
  endtask

  // Lamp invariant: one lamp per approach, at most one non-red approach.
  task automatic check_invariant();
    int nonred;
    logic ok;
    ok = 1'b1;
    nonred = 0;
    for (int i = 0; i < N; i++) begin
      if ((red[i] + yellow[i] + green[i]) != 1) ok = 1'b0;
      if (!red[i]) nonred++;
    end
    if (nonred > 1) ok = 1'b0;
    check("invariant", 32'(ok), 32'd1);
  endtask

  task automatic check_cycle(input int t, input int fixed_dir);
    logic [N-1:0] er, ey, eg;
    logic [1:0]   eph, edir;
    logic         est;
    model(t, fixed_dir, er, ey, eg, eph, edir, est);
    check("red",         32'(red),         32'(er));
    check("yellow",      32'(yellow),      32'(ey));
    check("green",       32'(green),       32'(eg));
    check("phase",       32'(phase),       32'(eph));
    check("active_dir",  32'(active_dir),  32'(edir));
    check("phase_start", 32'(phase_start), 32'(est));
    check_invariant();
  endtask

  // Drive veh_req for the next cycle; ignored in the default build.
  task automatic drive_req();
`ifdef INTERSECTION_DEMAND_SKIP_EN
    veh_req = '1;
`else
    veh_req = N'($urandom_range(0, (1 << N) - 1));
`endif
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_red"},    32'(red),         32'h7);
    check({tag, "_yellow"}, 32'(yellow),      32'h0);
    check({tag, "_green"},  32'(green),       32'h0);
    check({tag, "_phase"},  32'(phase),       32'h0);
    check({tag, "_dir"},    32'(active_dir),  32'(N - 1));
    check({tag, "_start"},  32'(phase_start), 32'h1);
  endtask

  initial begin
    rst = 1'b1;
    veh_req = '0;
    apply_reset();
    check_reset_values("rst");

    // Rotation run with randomized demand; sample on the falling edge.
    rst = 1'b0;
    start_cnt = 0;
    check_cycle(0, -1);
    for (int t = 1; t <= 3 * N * P + 5; t++) begin
      drive_req();
      @(posedge clk);
      @(negedge clk);
      check_cycle(t, -1);
      if (t >= A && t < A + N * P && phase_start) start_cnt++;
      if (t == A + N * P) check("wrap_dir", 32'(active_dir), 32'd0);
    end
    check("starts_per_rotation", 32'(start_cnt), 32'(3 * N));

    // Run into YELLOW of approach 1, then reset mid-phase.
    apply_reset();
    rst = 1'b0;
    check_cycle(0, -1);
    for (int t = 1; t <= A + P + G; t++) begin
      drive_req();
      @(posedge clk);
      @(negedge clk);
      check_cycle(t, -1);
    end
    check("pre_abort_yellow", 32'(yellow), 32'h2);
    rst = 1'b1;
    #1;
    check_reset_values("abort");
    @(posedge clk);
    @(negedge clk);
    check_reset_values("abort_hold");
    rst = 1'b0;
    check_cycle(0, -1);
    for (int t = 1; t <= 2 * P; t++) begin
      drive_req();
      @(posedge clk);
      @(negedge clk);
      check_cycle(t, -1);
    end

`ifdef INTERSECTION_DEMAND_SKIP_EN
    // Only approach 2 requests: every grant goes to it.
    veh_req = 3'b100;
    apply_reset();
    rst = 1'b0;
    check_cycle(0, 2);
    for (int t = 1; t <= 3 * P; t++) begin
      @(posedge clk);
      @(negedge clk);
      check_cycle(t, 2);
    end

    // No demand for 10 cycles: hold all red, no phase_start pulses.
    veh_req = '0;
    apply_reset();
    rst = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      @(posedge clk);
      @(negedge clk);
      check("wait_red",   32'(red),         32'h7);
      check("wait_start", 32'(phase_start), 32'h0);
      check("wait_phase", 32'(phase),       32'h0);
    end
    veh_req = 3'b010;
    @(posedge clk);
    @(negedge clk);
    check("grant_green", 32'(green),       32'h2);
    check("grant_dir",   32'(active_dir),  32'h1);
    check("grant_start", 32'(phase_start), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
